aquila_mem_arbiter: RTL and testbench

Two-to-one cache-line memory arbiter that lets the I-cache and D-cache miss ports of aquila_top share one main-memory line port. Each requester issues a single-cycle strobe. The arbiter registers the request and serialises transactions with round-robin priority. It drives one outstanding line transfer at a time and returns a one-cycle done pulse with the line data to the winning requester.

---
 rtl/aquila_mem_arbiter.sv | 152 +++++++++++++++
 tb/tb_aquila_mem_arbiter.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aquila_mem_arbiter.sv
// Two-to-one cache-line arbiter: I-cache and D-cache miss ports share one memory line port.
// Requests are captured from single-cycle strobes and served one at a time, round-robin on ties.
module aquila_mem_arbiter #(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned LINE_WIDTH  = 256,
  parameter int unsigned LINE_OFFSET = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  icache_strobe,
  input  logic [ADDR_WIDTH-1:0] icache_addr,
  output logic                  icache_done,
  output logic [LINE_WIDTH-1:0] icache_datain,
  input  logic                  dcache_strobe,
  input  logic [ADDR_WIDTH-1:0] dcache_addr,
  input  logic                  dcache_rw,
  input  logic [LINE_WIDTH-1:0] dcache_dataout,
  output logic                  dcache_done,
  output logic [LINE_WIDTH-1:0] dcache_datain,
  output logic                  mem_strobe,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_rw,
  output logic [LINE_WIDTH-1:0] mem_dataout,
  input  logic                  mem_done,
  input  logic [LINE_WIDTH-1:0] mem_datain,
  output logic                  busy,
  output logic                  proto_err
);

  localparam logic [ADDR_WIDTH-1:0] OFFSET_MASK =
    ADDR_WIDTH'((64'd1 << LINE_OFFSET) - 64'd1);
  localparam logic GNT_I = 1'b0;
  localparam logic GNT_D = 1'b1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_e;

  state_e                state_q;
  logic                  i_pend_q, d_pend_q;
  logic                  i_pend_d, d_pend_d;
  logic [ADDR_WIDTH-1:0] i_addr_q, d_addr_q;
  logic                  d_rw_q;
  logic [LINE_WIDTH-1:0] d_data_q;
  logic                  last_q, win_q, grant_d;
  logic                  mem_strobe_q, mem_rw_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [LINE_WIDTH-1:0] mem_data_q, line_q;
  logic                  i_done_q, d_done_q, busy_q, err_q;
  logic                  i_release_c, d_release_c;
  logic                  i_drop_c, d_drop_c, i_take_c, d_take_c;

  // Request capture; a strobe during the owner's own done cycle re-arms its pending flag.
  always_comb begin
    i_release_c = (state_q == S_DONE) && (win_q == GNT_I);
    d_release_c = (state_q == S_DONE) && (win_q == GNT_D);
    i_drop_c    = icache_strobe && i_pend_q && !i_release_c;
    d_drop_c    = dcache_strobe && d_pend_q && !d_release_c;
    i_take_c    = icache_strobe && !i_drop_c;
    d_take_c    = dcache_strobe && !d_drop_c;
    i_pend_d    = i_pend_q;
    d_pend_d    = d_pend_q;
    if (i_release_c) i_pend_d = 1'b0;
    if (d_release_c) d_pend_d = 1'b0;
    if (i_take_c)    i_pend_d = 1'b1;
    if (d_take_c)    d_pend_d = 1'b1;
    grant_d = (i_pend_q && d_pend_q) ? ~last_q : d_pend_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      i_pend_q     <= 1'b0;
      d_pend_q     <= 1'b0;
      i_addr_q     <= '0;
      d_addr_q     <= '0;
      d_rw_q       <= 1'b0;
      d_data_q     <= '0;
      last_q       <= GNT_D;
      win_q        <= GNT_I;
      mem_strobe_q <= 1'b0;
      mem_rw_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_data_q   <= '0;
      line_q       <= '0;
      i_done_q     <= 1'b0;
      d_done_q     <= 1'b0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      i_pend_q <= i_pend_d;
      d_pend_q <= d_pend_d;
      if (i_take_c) i_addr_q <= icache_addr;
      if (d_take_c) begin
        d_addr_q <= dcache_addr;
        d_rw_q   <= dcache_rw;
        d_data_q <= dcache_dataout;
      end
      if (i_drop_c || d_drop_c) err_q <= 1'b1;

      case (state_q)
        S_IDLE: begin
          if (i_pend_q || d_pend_q) begin
            state_q      <= S_ISSUE;
            win_q        <= grant_d;
            last_q       <= grant_d;
            mem_strobe_q <= 1'b1;
            busy_q       <= 1'b1;
            if (grant_d == GNT_D) begin
              mem_addr_q <= d_addr_q & ~OFFSET_MASK;
              mem_rw_q   <= d_rw_q;
              mem_data_q <= d_data_q;
            end else begin
              mem_addr_q <= i_addr_q & ~OFFSET_MASK;
              mem_rw_q   <= 1'b0;
              mem_data_q <= '0;
            end
          end
        end
        S_ISSUE: begin
          mem_strobe_q <= 1'b0;
          state_q      <= S_WAIT;
        end
        S_WAIT: begin
          if (mem_done) begin
            line_q  <= mem_datain;
            state_q <= S_DONE;
            if (win_q == GNT_D) d_done_q <= 1'b1;
            else                i_done_q <= 1'b1;
          end
        end
        S_DONE: begin
          i_done_q <= 1'b0;
          d_done_q <= 1'b0;
          busy_q   <= 1'b0;
          state_q  <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign icache_done   = i_done_q;
  assign dcache_done   = d_done_q;
  assign icache_datain = line_q;
  assign dcache_datain = line_q;
  assign mem_strobe    = mem_strobe_q;
  assign mem_addr      = mem_addr_q;
  assign mem_rw        = mem_rw_q;
  assign mem_dataout   = mem_data_q;
  assign busy          = busy_q;
  assign proto_err     = err_q;

endmodule

// File: tb/tb_aquila_mem_arbiter.sv
// Scoreboard bench for aquila_mem_arbiter: stimulus queues requests into a request-level model,
// a negedge monitor predicts issue timing, round-robin winner and done pulses from those queues.
module tb_aquila_mem_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned LW = 256;
  localparam int NEVER = 2147483647;

  logic          clk = 1'b0;
  logic          rst;
  logic          icache_strobe, dcache_strobe, dcache_rw;
  logic [AW-1:0] icache_addr, dcache_addr;
  logic [LW-1:0] dcache_dataout;
  logic          icache_done, dcache_done;
  logic [LW-1:0] icache_datain, dcache_datain;
  logic          mem_strobe, mem_rw, mem_done, busy, proto_err;
  logic [AW-1:0] mem_addr;
  logic [LW-1:0] mem_dataout, mem_datain;

  aquila_mem_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW), .LINE_OFFSET(5)) dut (
    .clk(clk), .rst(rst),
    .icache_strobe(icache_strobe), .icache_addr(icache_addr),
    .icache_done(icache_done), .icache_datain(icache_datain),
    .dcache_strobe(dcache_strobe), .dcache_addr(dcache_addr), .dcache_rw(dcache_rw),
    .dcache_dataout(dcache_dataout), .dcache_done(dcache_done), .dcache_datain(dcache_datain),
    .mem_strobe(mem_strobe), .mem_addr(mem_addr), .mem_rw(mem_rw), .mem_dataout(mem_dataout),
    .mem_done(mem_done), .mem_datain(mem_datain),
    .busy(busy), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [AW-1:0] addr;
    logic          rw;
    logic [LW-1:0] data;
    int            t;
    int            done_c;
  } req_t;

  typedef struct {
    logic          is_d;
    logic          rw;
    logic [LW-1:0] data;
    int            c;
  } exp_done_t;

  req_t      iq[$];
  req_t      dq[$];
  exp_done_t done_q[$];
  logic      grant_log[$];

  int n_chk = 0;
  int n_fail = 0;

  logic          in_txn = 1'b0;
  logic          cur_d = 1'b0;
  logic          last_d = 1'b1;
  req_t          cur;
  int            last_done = -100;
  int            err_from = NEVER;
  int            plan_c = -1;
  int            wait_lo = -1;
  int            wait_hi = -1;
  int            man_pulse_c = -1;
  int            mem_lat = 0;
  logic          man_mem = 1'b0;
  logic          stray_en = 1'b0;
  logic [LW-1:0] plan_data = '0;

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] v;
    v = '0;
    for (int i = 0; i < int'(LW / 32); i++) v[i*32 +: 32] = $urandom();
    return v;
  endfunction

  function automatic logic [AW-1:0] line_addr(input logic [AW-1:0] a);
    return (a >> 5) << 5;
  endfunction

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // A request is legal if the requester has nothing outstanding, or its done pulse is this cycle.
  task automatic model_strobe(input logic is_d, input logic [AW-1:0] a, input logic rw,
                              input logic [LW-1:0] d);
    int n;
    int dc;
    n  = is_d ? dq.size() : iq.size();
    dc = -1;
    if (n == 1) dc = is_d ? dq[0].done_c : iq[0].done_c;
    if (n == 0 || (n == 1 && dc == cyc)) begin
      if (is_d) dq.push_back('{a, rw, d, cyc, -1});
      else      iq.push_back('{a, 1'b0, d, cyc, -1});
    end else if (err_from == NEVER) begin
      err_from = cyc + 1;
    end
  endtask

  task automatic issue(input logic si, input logic [AW-1:0] ai, input logic sd,
                       input logic [AW-1:0] ad, input logic rwd, input logic [LW-1:0] dd);
    icache_strobe  = si;
    icache_addr    = ai;
    dcache_strobe  = sd;
    dcache_addr    = ad;
    dcache_rw      = rwd;
    dcache_dataout = dd;
    if (si) model_strobe(1'b0, ai, 1'b0, dd);
    if (sd) model_strobe(1'b1, ad, rwd, dd);
    step();
    icache_strobe = 1'b0;
    dcache_strobe = 1'b0;
  endtask

  task automatic flush_model();
    iq.delete();
    dq.delete();
    done_q.delete();
    in_txn    = 1'b0;
    last_d    = 1'b1;
    last_done = -100;
    err_from  = NEVER;
    plan_c    = -1;
    wait_lo   = -1;
    wait_hi   = -1;
  endtask

  task automatic wait_idle();
    logic ok;
    ok = 1'b0;
    for (int k = 0; k < 300; k++) begin
      if (iq.size() == 0 && dq.size() == 0 && !in_txn) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    if (!ok) chk("drain_timeout", LW'(ok), LW'(1'b1));
  endtask

  task automatic check_reset_outputs();
    chk("rst_mem_strobe", LW'(mem_strobe), '0);
    chk("rst_mem_addr", LW'(mem_addr), '0);
    chk("rst_mem_rw", LW'(mem_rw), '0);
    chk("rst_mem_dataout", mem_dataout, '0);
    chk("rst_icache_done", LW'(icache_done), '0);
    chk("rst_dcache_done", LW'(dcache_done), '0);
    chk("rst_icache_datain", icache_datain, '0);
    chk("rst_dcache_datain", dcache_datain, '0);
    chk("rst_busy", LW'(busy), '0);
    chk("rst_proto_err", LW'(proto_err), '0);
  endtask

  // Memory side: scheduled completions, directed pulses and random stray pulses outside WAIT.
  always @(posedge clk) begin
    #1;
    if (cyc == man_pulse_c) begin
      mem_done   = 1'b1;
      mem_datain = rand_line();
    end else if (!man_mem && cyc == plan_c) begin
      mem_done   = 1'b1;
      mem_datain = plan_data;
    end else if (!man_mem && stray_en && !(cyc >= wait_lo && cyc <= wait_hi)
                 && $urandom_range(0, 7) == 0) begin
      mem_done   = 1'b1;
      mem_datain = rand_line();
    end else begin
      mem_done   = 1'b0;
      mem_datain = rand_line();
    end
  end

  always @(negedge clk) begin : monitor
    logic      ci, cd, ei, ed, wd;
    int        tmin, exp_c, lat;
    exp_done_t e;
    if (!rst) begin
      ci = iq.size() > 0;
      cd = dq.size() > 0;
      if (!in_txn && (ci || cd)) begin
        tmin = NEVER;
        if (ci) tmin = iq[0].t;
        if (cd && dq[0].t < tmin) tmin = dq[0].t;
        exp_c = (tmin > last_done) ? tmin + 2 : last_done + 2;
        if (mem_strobe || cyc == exp_c)
          chk("issue_cycle", LW'({mem_strobe, 32'(cyc)}), LW'({1'b1, 32'(exp_c)}));
      end else if (mem_strobe) begin
        chk("spurious_strobe", LW'(mem_strobe), LW'(1'b0));
      end

      if (mem_strobe && !in_txn && (ci || cd)) begin
        ei = ci && (iq[0].t <= cyc - 2);
        ed = cd && (dq[0].t <= cyc - 2);
        if (ei || ed) begin
          wd     = (ei && ed) ? !last_d : ed;
          cur    = wd ? dq[0] : iq[0];
          cur_d  = wd;
          last_d = wd;
          in_txn = 1'b1;
          grant_log.push_back(wd);
          chk("mem_addr", LW'(mem_addr), LW'(line_addr(cur.addr)));
          chk("mem_rw", LW'(mem_rw), LW'(wd ? cur.rw : 1'b0));
          if (wd && cur.rw) chk("mem_dataout", mem_dataout, cur.data);
          lat       = (mem_lat != 0) ? mem_lat : $urandom_range(1, 4);
          plan_c    = cyc + lat;
          plan_data = rand_line();
          wait_lo   = cyc + 1;
          wait_hi   = plan_c;
          if (wd) dq[0].done_c = plan_c + 1;
          else    iq[0].done_c = plan_c + 1;
          done_q.push_back('{wd, wd ? cur.rw : 1'b0, plan_data, plan_c + 1});
        end
      end

      chk("busy", LW'(busy), LW'(in_txn));
      chk("proto_err", LW'(proto_err), LW'(cyc >= err_from));
      if (in_txn && !mem_strobe)
        chk("mem_hold", LW'({mem_rw, mem_addr}),
            LW'({cur_d ? cur.rw : 1'b0, line_addr(cur.addr)}));

      if (done_q.size() > 0 && cyc == done_q[0].c) begin
        e = done_q.pop_front();
        chk("done_pulse", LW'({icache_done, dcache_done}), LW'({!e.is_d, e.is_d}));
        if (!e.rw) chk("done_data", e.is_d ? dcache_datain : icache_datain, e.data);
        if (e.is_d) void'(dq.pop_front());
        else        void'(iq.pop_front());
        in_txn    = 1'b0;
        last_done = cyc;
      end else if (icache_done || dcache_done) begin
        chk("spurious_done", LW'({icache_done, dcache_done}), '0);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic          found;
    int            t0;
    logic          si, sd;
    rst            = 1'b1;
    icache_strobe  = 1'b0;
    icache_addr    = '0;
    dcache_strobe  = 1'b0;
    dcache_addr    = '0;
    dcache_rw      = 1'b0;
    dcache_dataout = '0;
    repeat (3) step();
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs();
    step();

    // I-cache read of an unaligned address, memory answers 3 cycles after the strobe.
    mem_lat = 3;
    issue(1'b1, 32'h8000_0024, 1'b0, '0, 1'b0, '0);
    wait_idle();

    // D-cache write line.
    issue(1'b0, '0, 1'b1, 32'h1000_0040, 1'b1, {32{8'hA5}});
    wait_idle();

    // Simultaneous strobes from reset: I wins the first tie, then grants alternate.
    rst = 1'b1;
    flush_model();
    step();
    rst = 1'b0;
    grant_log.delete();
    mem_lat = 0;
    for (int r = 0; r < 2; r++) begin
      issue(1'b1, $urandom(), 1'b1, $urandom(), 1'b0, rand_line());
      wait_idle();
    end
    chk("tie_rounds", LW'(grant_log.size()), LW'(4));
    for (int k = 0; k < grant_log.size() && k < 4; k++)
      chk("tie_order", LW'(grant_log[k]), LW'(k % 2));

    // Second I strobe while the first is waiting on memory.
    mem_lat = 3;
    issue(1'b1, 32'h4000_0104, 1'b0, '0, 1'b0, '0);
    step();
    step();
    issue(1'b1, 32'h5000_0000, 1'b0, '0, 1'b0, '0);
    wait_idle();

    // Stray mem_done while idle.
    man_pulse_c = cyc + 1;
    repeat (4) step();

    // Fastest memory: done lands at strobe cycle + 4, the fifth cycle counting the strobe.
    mem_lat = 1;
    t0 = cyc;
    issue(1'b1, $urandom(), 1'b0, '0, 1'b0, '0);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (icache_done) break;
    end
    chk("min_latency", LW'(cyc - t0), LW'(4));
    step();
    wait_idle();

    // New strobe in the same cycle as the requester's own done pulse.
    mem_lat = 2;
    found = 1'b0;
    issue(1'b1, $urandom(), 1'b0, '0, 1'b0, '0);
    for (int k = 0; k < 20; k++) begin
      step();
      if (icache_done) begin
        issue(1'b1, 32'h7000_0011, 1'b0, '0, 1'b0, '0);
        found = 1'b1;
        break;
      end
    end
    chk("redone_seen", LW'(found), LW'(1'b1));
    wait_idle();

    // Random traffic with random memory latency and stray completions.
    mem_lat  = 0;
    stray_en = 1'b1;
    for (int k = 0; k < 400; k++) begin
      si = (iq.size() == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 49) == 0);
      sd = (dq.size() == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 49) == 0);
      issue(si, $urandom(), sd, $urandom(), 1'($urandom_range(0, 1)), rand_line());
    end
    stray_en = 1'b0;
    wait_idle();
    step();

    // Reset while a D read is waiting on memory, then a late completion.
    man_mem = 1'b1;
    mem_lat = 3;
    issue(1'b0, '0, 1'b1, 32'h2000_0060, 1'b0, '0);
    step();
    step();
    rst = 1'b1;
    flush_model();
    man_pulse_c = cyc + 2;
    step();
    rst = 1'b0;
    repeat (3) step();
    @(negedge clk);
    check_reset_outputs();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
